// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit seven-segment scan driver with frame-synchronous double buffering.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks digits above the highest non-zero nibble.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  output logic [7:0]  cathode_array,
  output logic [7:0]  anode_array,
  output logic        frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [2:0]    idx_reg, idx_next;
  logic          slot_end, frame_end;

  logic [31:0]   disp_reg, pend_data_reg;
  logic [7:0]    dp_reg, pend_dp_reg;
  logic          pend_flag_reg;

  logic [7:0]    anode_reg, anode_next;
  logic [7:0]    cathode_reg, cathode_next;
  logic          frame_tick_reg;

  logic [3:0]    nibble;
  logic [6:0]    seg_n;
  logic [7:0]    nz;
  logic [7:0]    nz_at_or_above;

  assign slot_end  = (count_reg == CW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx_reg == 3'd7);

  // Per-digit "nibble is non-zero" flags for leading-zero suppression.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_nz
      assign nz[gi] = |disp_reg[4*gi +: 4];
    end
  endgenerate

  assign nz_at_or_above = nz >> idx_reg;
  assign nibble         = disp_reg[{idx_reg, 2'b00} +: 4];

  always_comb begin
    seg_n = 7'h7F;
    case (nibble)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end

  always_comb begin
    count_next   = slot_end ? '0 : count_reg + CW'(1);
    idx_next     = slot_end ? idx_reg + 3'd1 : idx_reg;
    state_next   = state_reg;
    anode_next   = 8'hFF;
    cathode_next = 8'hFF;
    case (state_reg)
      BLANK: if (count_next == CW'(BLANK_CYCLES)) state_next = SHOW;
      SHOW:  if (slot_end) state_next = BLANK;
      default: state_next = BLANK;
    endcase
    if (state_reg == SHOW) begin
      anode_next   = ~(8'd1 << idx_reg);
      cathode_next = {~dp_reg[idx_reg], seg_n};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      // Digit 0 is always lit so a zero value still shows "0".
      if (idx_reg != 3'd0 && nz_at_or_above == 8'd0) cathode_next[6:0] = 7'h7F;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= BLANK;
      count_reg      <= '0;
      idx_reg        <= 3'd0;
      anode_reg      <= 8'hFF;
      cathode_reg    <= 8'hFF;
      frame_tick_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      idx_reg        <= idx_next;
      anode_reg      <= anode_next;
      cathode_reg    <= cathode_next;
      frame_tick_reg <= frame_end;
    end
  end

  // A write landing on the boundary cycle bypasses the pending buffer entirely.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_reg      <= 32'd0;
      dp_reg        <= 8'd0;
      pend_data_reg <= 32'd0;
      pend_dp_reg   <= 8'd0;
      pend_flag_reg <= 1'b0;
    end else if (frame_end) begin
      if (wr_en) begin
        disp_reg <= wr_data;
        dp_reg   <= wr_dp;
      end else if (pend_flag_reg) begin
        disp_reg <= pend_data_reg;
        dp_reg   <= pend_dp_reg;
      end
      pend_flag_reg <= 1'b0;
    end else if (wr_en) begin
      pend_data_reg <= wr_data;
      pend_dp_reg   <= wr_dp;
      pend_flag_reg <= 1'b1;
    end
  end

  assign anode_array   = anode_reg;
  assign cathode_array = cathode_reg;
  assign frame_tick    = frame_tick_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised self-checking bench for seg7_scan_driver against a cycle-count based reference model.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp;
  logic [7:0]  cathode_array;
  logic [7:0]  anode_array;
  logic        frame_tick;

  seg7_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
    .cathode_array(cathode_array), .anode_array(anode_array), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int          n_checks = 0;
  int          n_pass   = 0;

  // Model: k_m counts cycles since reset; slot = k_m/8, phase = k_m%8, frame = 64 cycles.
  int unsigned k_m;
  logic [31:0] disp_m, pend_m;
  logic [7:0]  dpd_m, pdp_m;
  bit          pflag_m;
  logic [7:0]  exp_an, exp_cat;
  logic        exp_tick;

  task automatic tick(input bit rst, input bit we, input logic [31:0] d, input logic [7:0] p);
    int c;
    int di;
    reset = rst; wr_en = we; wr_data = d; wr_dp = p;
    @(posedge clk);
    if (rst) begin
      exp_an = 8'hFF; exp_cat = 8'hFF; exp_tick = 1'b0;
      k_m = 0; disp_m = 0; dpd_m = 0; pend_m = 0; pdp_m = 0; pflag_m = 0;
    end else begin
      c  = int'(k_m % 8);
      di = int'((k_m / 8) % 8);
      exp_an = 8'hFF; exp_cat = 8'hFF;
      if (c >= 2) begin
        exp_an  = ~(8'd1 << di);
        exp_cat = SEG[(disp_m >> (4 * di)) & 32'hF];
        exp_cat[7] = ~dpd_m[di];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (di > 0 && (disp_m >> (4 * di)) == 0) exp_cat[6:0] = 7'h7F;
`endif
      end
      exp_tick = (k_m % 64 == 63);
      if (k_m % 64 == 63) begin
        if (we) begin disp_m = d; dpd_m = p; end
        else if (pflag_m) begin disp_m = pend_m; dpd_m = pdp_m; end
        pflag_m = 0;
      end else if (we) begin
        pend_m = d; pdp_m = p; pflag_m = 1;
      end
      k_m++;
    end
    #1;
    reset = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 32'h0, 8'h0);
      n_checks++;
      if ({anode_array, cathode_array, frame_tick} !== {8'hFF, 8'hFF, 1'b0})
        $display("FAIL reset an=%h cat=%h tick=%b expected an=FF cat=FF tick=0", anode_array, cathode_array, frame_tick);
      else n_pass++;
    end
  endtask

  task automatic test_idle_frame();
    int ticks = 0;
    for (int i = 0; i < 64; i++) begin
      tick(0, 0, 32'h0, 8'h0);
      if (frame_tick === 1'b1) ticks++;
      n_checks++;
      if ({anode_array, cathode_array, frame_tick} !== {exp_an, exp_cat, exp_tick})
        $display("FAIL idle k=%0d an=%h cat=%h tick=%b expected an=%h cat=%h tick=%b", k_m, anode_array, cathode_array, frame_tick, exp_an, exp_cat, exp_tick);
      else n_pass++;
    end
    n_checks++;
    if (ticks !== 1) $display("FAIL idle_tick_count got %0d expected 1", ticks);
    else n_pass++;
  endtask

  task automatic test_mid_frame_write();
    bit saw = 0;
    for (int i = 0; i < 140; i++) begin
      tick(0, i == 20, 32'h0000_00A5, 8'h01);
      if (anode_array === 8'hFE && cathode_array === 8'h12) saw = 1;
      n_checks++;
      if ({anode_array, cathode_array, frame_tick} !== {exp_an, exp_cat, exp_tick})
        $display("FAIL mid_write k=%0d an=%h cat=%h tick=%b expected an=%h cat=%h tick=%b", k_m, anode_array, cathode_array, frame_tick, exp_an, exp_cat, exp_tick);
      else n_pass++;
    end
    n_checks++;
    if (!saw) $display("FAIL mid_write_digit0 got no 12 on digit0 expected 12");
    else n_pass++;
  endtask

  task automatic test_two_writes();
    bit saw_f9 = 0;
    for (int i = 0; i < 130; i++) begin
      tick(0, i == 5 || i == 10, (i == 5) ? 32'h1111_1111 : 32'h2222_2222, 8'h00);
      if (cathode_array === 8'hF9) saw_f9 = 1;
      n_checks++;
      if ({anode_array, cathode_array, frame_tick} !== {exp_an, exp_cat, exp_tick})
        $display("FAIL two_writes k=%0d an=%h cat=%h tick=%b expected an=%h cat=%h tick=%b", k_m, anode_array, cathode_array, frame_tick, exp_an, exp_cat, exp_tick);
      else n_pass++;
    end
    n_checks++;
    if (saw_f9) $display("FAIL two_writes_last_wins got F9 displayed expected never");
    else n_pass++;
  endtask

  task automatic test_boundary_write();
    bit done = 0;
    bit saw_8e = 0;
    bit saw_b0 = 0;
    bit bwe;
    for (int i = 0; i < 130; i++) begin
      bwe = (k_m % 64 == 63) && !done;
      tick(0, (i == 2) || bwe, bwe ? 32'h0000_000F : 32'h0000_0003, 8'h00);
      if (bwe) begin
        done = 1;
        n_checks++;
        if (dut.pend_flag_reg !== 1'b0) $display("FAIL boundary_pending_flag got %b expected 0", dut.pend_flag_reg);
        else n_pass++;
      end
      if (anode_array === 8'hFE && cathode_array === 8'h8E) saw_8e = 1;
      if (anode_array === 8'hFE && cathode_array === 8'hB0) saw_b0 = 1;
      n_checks++;
      if ({anode_array, cathode_array, frame_tick} !== {exp_an, exp_cat, exp_tick})
        $display("FAIL boundary_write k=%0d an=%h cat=%h tick=%b expected an=%h cat=%h tick=%b", k_m, anode_array, cathode_array, frame_tick, exp_an, exp_cat, exp_tick);
      else n_pass++;
    end
    n_checks++;
    if (!saw_8e || saw_b0) $display("FAIL boundary_digit0 got saw8E=%b sawB0=%b expected 1 0", saw_8e, saw_b0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    while (k_m % 64 != 36) tick(0, 0, 32'h0, 8'h0);
    tick(0, 0, 32'h0, 8'h0);
    n_checks++;
    if (anode_array !== 8'hEF) $display("FAIL pre_reset_digit4 got an=%h expected EF", anode_array);
    else n_pass++;
    tick(1, 0, 32'h0, 8'h0);
    n_checks++;
    if ({anode_array, cathode_array, dut.disp_reg} !== {8'hFF, 8'hFF, 32'h0})
      $display("FAIL reset_mid_scan an=%h cat=%h disp=%h expected FF FF 00000000", anode_array, cathode_array, dut.disp_reg);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 32'h0, 8'h0);
      n_checks++;
      if ({anode_array, cathode_array, frame_tick} !== {exp_an, exp_cat, exp_tick})
        $display("FAIL restart k=%0d an=%h cat=%h tick=%b expected an=%h cat=%h tick=%b", k_m, anode_array, cathode_array, frame_tick, exp_an, exp_cat, exp_tick);
      else n_pass++;
    end
  endtask

  task automatic test_leading_zero();
    bit bad = 0;
    logic [7:0] want;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    want = 8'hFF;
`else
    want = 8'hC0;
`endif
    for (int i = 0; i < 140; i++) begin
      tick(0, i == 3, 32'h0000_0A05, 8'h00);
      if (i > 70 && anode_array === 8'hF7 && cathode_array !== want) bad = 1;
      n_checks++;
      if ({anode_array, cathode_array, frame_tick} !== {exp_an, exp_cat, exp_tick})
        $display("FAIL leading_zero k=%0d an=%h cat=%h tick=%b expected an=%h cat=%h tick=%b", k_m, anode_array, cathode_array, frame_tick, exp_an, exp_cat, exp_tick);
      else n_pass++;
    end
    n_checks++;
    if (bad) $display("FAIL leading_zero_digit3 got a value other than %h on digit3", want);
    else n_pass++;
  endtask

  task automatic test_random();
    bit we;
    for (int i = 0; i < 400; i++) begin
      we = (k_m % 64 == 63) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      tick(0, we, $urandom >> $urandom_range(0, 31), 8'($urandom));
      n_checks++;
      if ({anode_array, cathode_array, frame_tick} !== {exp_an, exp_cat, exp_tick})
        $display("FAIL random k=%0d an=%h cat=%h tick=%b expected an=%h cat=%h tick=%b", k_m, anode_array, cathode_array, frame_tick, exp_an, exp_cat, exp_tick);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 32'h0; wr_dp = 8'h0;
    test_reset();
    test_idle_frame();
    test_mid_frame_write();
    test_two_writes();
    test_boundary_write();
    test_reset_mid_scan();
    test_leading_zero();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
